seq_muldiv_unit: RTL and testbench
==================================

// Module: seq_muldiv_unit
// PURPOSE
//  Multi-cycle unsigned multiply/divide unit downstream of the register file.
//  Consumes the two register read ports as operands and returns one 32-bit result.
//  The result goes back through the register-file write port (write enable, address, data).
//  Radix-2 iterative: one partial product or restoring-division step per clock.
// PARAMETERS
//  WIDTH   32  operand/result width; iteration count equals WIDTH
//  AW      5   register address width
// PORTS
//  clk       in   1      system clock, rising edge
//  rst       in   1      asynchronous, active-high reset
//  start     in   1      request; sampled only in IDLE
//  op        in   2      00 MUL_LO, 01 MUL_HI, 10 DIV_Q, 11 DIV_R (all unsigned)
//  dest      in   AW     destination register address
//  src_A     in   WIDTH  multiplicand / dividend (register read port A)
//  src_B     in   WIDTH  multiplier / divisor (register read port B)
//  busy      out  1      high from the cycle after start acceptance until WB ends
//  done      out  1      one-cycle pulse in the WB cycle
//  wb_en     out  1      register-file write enable (drives L_S), one-cycle pulse
//  wb_addr   out  AW     write address (drives Wt_addr)
//  wb_data   out  WIDTH  write data (drives Wt_data)
//  div_zero  out  1      high with done when a DIV op had src_B==0; else low
// BEHAVIOUR
//  States: IDLE -> RUN -> WB -> IDLE; all outputs registered.
//  Reset (any time, incl. mid-RUN or WB): state=IDLE, counter=0, all outputs 0.
//   - The in-flight op is discarded and no wb_en is issued.
//  IDLE:
//   - On start=1 at edge k, latch op, dest, src_A, src_B.
//   - Clear the 2*WIDTH accumulator and set count=WIDTH.
//   - Go to RUN (busy=1 from k+1).
//   - DIV with src_B==0 goes straight to WB instead.
//  RUN, one step per cycle, count decrements:
//   - MUL: if LSB of multiplier is 1, add multiplicand to the upper half (WIDTH+1-bit sum).
//     Then shift the {carry, acc} pair right by 1.
//   - DIV: shift {rem, quo} left by 1 and trial-subtract the divisor from rem (WIDTH+1 bits).
//     If non-negative, keep the difference and set quo LSB=1.
//   - When count reaches 1 and that step completes, go to WB.
//  WB, exactly one cycle:
//   - done=1 and busy=1.
//   - wb_data = MUL_LO acc[WIDTH-1:0], MUL_HI acc[2W-1:W], DIV_Q quotient, DIV_R remainder.
//   - wb_addr=dest; wb_en=1 unless dest==0 (r0 is never written; done still pulses).
//   - Then IDLE.
//  Latency:
//   - Start accepted at edge k gives WB at edge k+WIDTH+1 (k+33 for WIDTH=32).
//   - Divide-by-zero gives WB at edge k+1.
//  Divide-by-zero: DIV_Q returns all-ones, DIV_R returns src_A, div_zero=1 during WB.
//  Outside WB: wb_en, done and div_zero are 0; wb_data and wb_addr hold their last value.
//  start while busy (RUN or WB) is ignored; there is no queuing.
//   - Operands must be re-presented after returning to IDLE.
//  Operand inputs may change freely after acceptance; only the latched copies are used.
//  Back-to-back: start in the first IDLE cycle after WB is accepted normally.
// TESTING
//  1. start op=00 A=7 B=6 dest=3 -> wb_en=1, wb_addr=3, wb_data=42 at edge k+33; busy low at k+34.
//  2. op=01 A=B=0xFFFFFFFF -> wb_data=0xFFFFFFFE; op=00 same operands -> wb_data=0x00000001.
//  3. op=10 A=100 B=7 -> wb_data=14; op=11 same -> wb_data=2; div_zero=0.
//  4. op=10 A=55 B=0 -> WB at k+1, wb_data=0xFFFFFFFF, div_zero=1.
//     op=11 A=55 B=0 -> wb_data=55, div_zero=1.
//  5. start at k, second start (A=1,B=1) at k+5 -> single WB with the first result.
//     Assert rst at k+10 -> no wb_en ever, all outputs 0.
//  6. dest=0 op=00 A=3 B=3 -> done pulses at k+33, wb_en stays 0.
//     Immediate restart at k+34 -> next WB at k+67.

Source files
------------

// File: rtl/seq_muldiv_unit.sv
// Radix-2 iterative unsigned multiply/divide unit; one shift-add or restoring
// divide step per clock, result returned through the register-file write port.
module seq_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [AW-1:0]    dest,
  input  logic [WIDTH-1:0] src_A,
  input  logic [WIDTH-1:0] src_B,
  output logic             busy,
  output logic             done,
  output logic             wb_en,
  output logic [AW-1:0]    wb_addr,
  output logic [WIDTH-1:0] wb_data,
  output logic             div_zero
);

  // state | meaning
  // IDLE  | waiting for start, operands latched on acceptance
  // RUN   | one multiply or divide step per cycle, count decrements
  // WB    | result selected; registered outputs pulse on the following edge
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WB} state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state, state_nxt;
  logic [CW-1:0]      count;
  logic [1:0]         op_q;
  logic [AW-1:0]      dest_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] acc;
  logic               dz_q;

  logic               is_div;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_srem;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   result;

  assign is_div = op_q[1];

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = (op[1] && (src_B == '0)) ? S_WB : S_RUN;
      S_RUN:  if (count == CW'(1)) state_nxt = S_WB;
      S_WB:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // MUL keeps the shifting multiplier in b_q; DIV keeps {rem, quo} in acc.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : {WIDTH{1'b0}})};
    div_srem = acc[2*WIDTH-1:WIDTH-1];
    div_diff = div_srem - {1'b0, b_q};
    if (is_div) begin
      if (div_diff[WIDTH]) acc_step = {acc[2*WIDTH-2:0], 1'b0};
      else                 acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end
    case (op_q)
      2'b00:   result = acc[WIDTH-1:0];
      2'b01:   result = acc[2*WIDTH-1:WIDTH];
      2'b10:   result = dz_q ? {WIDTH{1'b1}} : acc[WIDTH-1:0];
      default: result = dz_q ? a_q : acc[2*WIDTH-1:WIDTH];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      count    <= '0;
      op_q     <= '0;
      dest_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      dz_q     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wb_en    <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_nxt;
      busy     <= (state != S_IDLE);
      done     <= (state == S_WB);
      wb_en    <= (state == S_WB) && (dest_q != '0);
      div_zero <= (state == S_WB) && dz_q;
      if (state == S_WB) begin
        wb_addr <= dest_q;
        wb_data <= result;
      end
      case (state)
        S_IDLE: if (start) begin
          op_q   <= op;
          dest_q <= dest;
          a_q    <= src_A;
          b_q    <= src_B;
          count  <= CW'(WIDTH);
          dz_q   <= op[1] && (src_B == '0);
          acc    <= op[1] ? {{WIDTH{1'b0}}, src_A} : '0;
        end
        S_RUN: begin
          acc   <= acc_step;
          count <= count - CW'(1);
          if (!is_div) b_q <= b_q >> 1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_muldiv_unit.sv
// Bench for seq_muldiv_unit: vector table plus corner sequences, with a
// scoreboard queue checked whenever the unit pulses done.
module tb_seq_muldiv_unit;
  localparam int W  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = '0;
  logic [AW-1:0] dest = '0;
  logic [W-1:0]  src_A = '0;
  logic [W-1:0]  src_B = '0;
  logic          busy, done, wb_en, div_zero;
  logic [AW-1:0] wb_addr;
  logic [W-1:0]  wb_data;

  seq_muldiv_unit #(.WIDTH(W), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .dest(dest),
    .src_A(src_A), .src_B(src_B), .busy(busy), .done(done), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  typedef struct {
    logic [W-1:0]  data;
    logic [AW-1:0] addr;
    logic          en;
    logic          dz;
    int            wcyc;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  typedef struct {
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [AW-1:0] dest;
    logic [W-1:0]  exp_data;
    logic          exp_dz;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic dz);
    logic [2*W-1:0] p;
    p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    dz = o[1] && (b == '0);
    case (o)
      2'b00:   r = p[W-1:0];
      2'b01:   r = p[2*W-1:W];
      2'b10:   r = dz ? {W{1'b1}} : a / b;
      default: r = dz ? a : a % b;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 want no pending op (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("wb_data", wb_data, e.data);
          chk("wb_addr", wb_addr, e.addr);
          chk("wb_en", wb_en, e.en);
          chk("div_zero", div_zero, e.dz);
          chk("wb_cycle", cyc, e.wcyc);
          chk("busy_in_wb", busy, 1);
        end
      end else if (wb_en || div_zero) begin
        chk("stray_wb_en_dz", {wb_en, div_zero}, 0);
      end
    end
  end

  // Accepted at the next rising edge; operands are scrambled right after.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [AW-1:0] d, input logic [W-1:0] xd, input logic xdz,
                       input bit push);
    exp_t x;
    op = o; src_A = a; src_B = b; dest = d; start = 1'b1;
    if (push) begin
      x.data = xd;
      x.addr = d;
      x.en   = (d != '0);
      x.dz   = xdz;
      x.wcyc = cyc + 1 + (xdz ? 1 : W + 1);
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    src_A = $urandom;
    src_B = $urandom;
    op    = 2'($urandom_range(0, 3));
    dest  = AW'($urandom_range(0, 31));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) return;
    end
    total++;
    bad++;
    $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
    sb.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] r;
    logic         dz;
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;
    int           d0;

    vecs[0]  = '{2'd0, 32'd7,          32'd6,          5'd3,  32'd42,         1'b0};
    vecs[1]  = '{2'd1, 32'hFFFFFFFF,   32'hFFFFFFFF,   5'd7,  32'hFFFFFFFE,   1'b0};
    vecs[2]  = '{2'd0, 32'hFFFFFFFF,   32'hFFFFFFFF,   5'd8,  32'h00000001,   1'b0};
    vecs[3]  = '{2'd2, 32'd100,        32'd7,          5'd10, 32'd14,         1'b0};
    vecs[4]  = '{2'd3, 32'd100,        32'd7,          5'd11, 32'd2,          1'b0};
    vecs[5]  = '{2'd2, 32'd55,         32'd0,          5'd12, 32'hFFFFFFFF,   1'b1};
    vecs[6]  = '{2'd3, 32'd55,         32'd0,          5'd13, 32'd55,         1'b1};
    vecs[7]  = '{2'd2, 32'd5,          32'd9,          5'd31, 32'd0,          1'b0};
    vecs[8]  = '{2'd3, 32'd5,          32'd9,          5'd31, 32'd5,          1'b0};
    vecs[9]  = '{2'd2, 32'hFFFFFFFF,   32'd1,          5'd1,  32'hFFFFFFFF,   1'b0};
    vecs[10] = '{2'd1, 32'h00010000,   32'h00010000,   5'd2,  32'h00000001,   1'b0};
    vecs[11] = '{2'd3, 32'hFFFFFFFF,   32'hFFFFFFFE,   5'd4,  32'h00000001,   1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_wb_addr", wb_addr, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_div_zero", div_zero, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest, vecs[i].exp_data, vecs[i].exp_dz, 1);
      wait_drain();
      @(posedge clk);
      #1;
      chk("busy_after_wb", busy, 0);
    end

    for (int i = 0; i < 6; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 2) ? '0 : ($urandom >> $urandom_range(0, 31));
      model(ro, ra, rb, r, dz);
      issue(ro, ra, rb, AW'($urandom_range(0, 31)), r, dz, 1);
      wait_drain();
      @(posedge clk);
      #1;
    end

    // start while busy is ignored: only the first op writes back
    d0 = done_cnt;
    issue(2'd0, 32'd7, 32'd6, 5'd3, 32'd42, 1'b0, 1);
    repeat (4) @(posedge clk);
    #1;
    op = 2'd0; src_A = 32'd1; src_B = 32'd1; dest = 5'd9; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_drain();
    repeat (40) @(posedge clk);
    #1;
    chk("single_wb_count", done_cnt - d0, 1);

    // reset mid-run discards the op
    issue(2'd0, 32'd5, 32'd5, 5'd4, 32'd25, 1'b0, 0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_outs", {done, wb_en, div_zero, wb_addr, wb_data}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    d0 = done_cnt;
    repeat (45) @(posedge clk);
    #1;
    chk("no_wb_after_rst", done_cnt - d0, 0);

    // dest 0 suppresses wb_en, then immediate restart
    issue(2'd0, 32'd3, 32'd3, 5'd0, 32'd9, 1'b0, 1);
    wait_drain();
    issue(2'd1, 32'h80000000, 32'd4, 5'd6, 32'd2, 1'b0, 1);
    wait_drain();
    @(posedge clk);
    #1;
    chk("busy_after_restart", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
